// File: rtl/crc16_rx_deframer.sv
// Bit-serial CRC-16 (0x8005, init 0) receive deframer: collects a 48-bit frame,
// checks the LFSR residue and offers payload/CRC/status over valid/ready.
module crc16_rx_deframer (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        frame_start,
  output logic [31:0] data_out,
  output logic [15:0] crc_rx,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [15:0] POLY = 16'h8005;
  localparam logic [5:0]  LAST_CNT = 6'd47;

  function automatic logic [15:0] lfsr_step(input logic [15:0] r, input logic b);
    logic c;
    c = b ^ r[15];
    return {r[14:0], 1'b0} ^ (c ? POLY : 16'h0000);
  endfunction

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic [15:0] r_lfsr, w_lfsr_nxt;
  logic [47:0] r_sh, w_sh_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic [15:0] r_crc, w_crc_nxt;
  logic        r_ok, w_ok_nxt;
  logic        r_err, w_err_nxt;
  logic        r_vld, w_vld_nxt;
  logic        r_ovr, w_ovr_nxt;

  logic        w_start;
  logic [15:0] w_lfsr_shift;
  logic [15:0] w_lfsr_first;
  logic [47:0] w_sh_shift;

  assign w_start      = bit_valid & frame_start;
  assign w_lfsr_shift = lfsr_step(r_lfsr, bit_in);
  assign w_lfsr_first = lfsr_step(16'h0000, bit_in);
  assign w_sh_shift   = {r_sh[46:0], bit_in};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lfsr_nxt  = r_lfsr;
    w_sh_nxt    = r_sh;
    w_data_nxt  = r_data;
    w_crc_nxt   = r_crc;
    w_ok_nxt    = r_ok;
    w_err_nxt   = r_err;
    w_vld_nxt   = r_vld;
    w_ovr_nxt   = r_ovr;

    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = 6'd1;
          w_lfsr_nxt  = w_lfsr_first;
          w_sh_nxt    = {47'd0, bit_in};
        end
      end

      S_SHIFT: begin
        if (bit_valid) begin
          if (frame_start) begin
            // A new start bit abandons the partial frame and becomes bit 47.
            w_ovr_nxt   = 1'b1;
            w_cnt_nxt   = 6'd1;
            w_lfsr_nxt  = w_lfsr_first;
            w_sh_nxt    = {47'd0, bit_in};
          end else begin
            w_cnt_nxt  = r_cnt + 6'd1;
            w_lfsr_nxt = w_lfsr_shift;
            w_sh_nxt   = w_sh_shift;
            if (r_cnt == LAST_CNT) begin
              w_state_nxt = S_HOLD;
              w_cnt_nxt   = 6'd0;
              w_data_nxt  = w_sh_shift[47:16];
              w_crc_nxt   = w_sh_shift[15:0];
              w_ok_nxt    = (w_lfsr_shift == 16'h0000);
              w_err_nxt   = (w_lfsr_shift != 16'h0000);
              w_vld_nxt   = 1'b1;
            end
          end
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          w_vld_nxt   = 1'b0;
          w_ok_nxt    = 1'b0;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
          // Start bit coinciding with the handshake opens the next frame at once.
          if (w_start) begin
            w_state_nxt = S_SHIFT;
            w_cnt_nxt   = 6'd1;
            w_lfsr_nxt  = w_lfsr_first;
            w_sh_nxt    = {47'd0, bit_in};
          end
        end else if (bit_valid) begin
          w_ovr_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_lfsr  <= 16'h0000;
      r_sh    <= 48'd0;
      r_data  <= 32'd0;
      r_crc   <= 16'h0000;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_vld   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_sh    <= w_sh_nxt;
      r_data  <= w_data_nxt;
      r_crc   <= w_crc_nxt;
      r_ok    <= w_ok_nxt;
      r_err   <= w_err_nxt;
      r_vld   <= w_vld_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  assign data_out  = r_data;
  assign crc_rx    = r_crc;
  assign crc_ok    = r_ok;
  assign crc_err   = r_err;
  assign out_valid = r_vld;
  assign overrun   = r_ovr;
  assign busy      = (r_state == S_SHIFT);

endmodule

// File: tb/tb_crc16_rx_deframer.sv
// Directed + randomized bench for crc16_rx_deframer; expected results come from
// polynomial long division over GF(2) on whole frames.
module tb_crc16_rx_deframer;

  logic        clk;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic        frame_start;
  logic [31:0] data_out;
  logic [15:0] crc_rx;
  logic        crc_ok;
  logic        crc_err;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        overrun;

  crc16_rx_deframer dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .frame_start(frame_start),
    .data_out   (data_out),
    .crc_rx     (crc_rx),
    .crc_ok     (crc_ok),
    .crc_err    (crc_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [15:0] c;
    logic        ok;
    logic        err;
    logic [31:0] cyc;
  } res_t;

  res_t        res_q[$];
  logic [31:0] cyc_cnt = 32'd0;
  int unsigned vld_seen = 0;
  int unsigned busy_seen = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

  // Collect every completed handshake plus activity counters, away from the clock edge.
  always @(negedge clk) begin
    if (out_valid && out_ready)
      res_q.push_back('{d: data_out, c: crc_rx, ok: crc_ok, err: crc_err, cyc: cyc_cnt});
    if (out_valid) vld_seen <= vld_seen + 1;
    if (busy) busy_seen <= busy_seen + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int rd       = 0;

  // Remainder of v(x) modulo x^16+x^15+x^2+1, by long division.
  function automatic logic [15:0] polymod(input logic [63:0] v);
    logic [63:0] t;
    t = v;
    for (int i = 63; i >= 16; i--)
      if (t[i]) t = t ^ (64'h18005 << (i - 16));
    return t[15:0];
  endfunction

  function automatic logic [15:0] good_crc(input logic [31:0] p);
    return polymod({16'h0000, p, 16'h0000});
  endfunction

  // The receiver's residue after a whole frame is frame(x)*x^16 mod P.
  function automatic logic frame_ok(input logic [47:0] f);
    return polymod({f, 16'h0000}) == 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send the top nb bits of f, MSB first; gappy inserts random idle beats.
  task automatic send_bits(input logic [47:0] f, input int nb, input bit gappy);
    for (int i = 47; i > 47 - nb; i--) begin
      if (gappy) begin
        bit_valid = 1'b0;
        frame_start = 1'b0;
        repeat ($urandom_range(2, 0)) tick();
      end
      bit_in      = f[i];
      bit_valid   = 1'b1;
      frame_start = (i == 47);
      tick();
    end
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    bit_in      = 1'b0;
  endtask

  task automatic wait_results(input int n, input string tag);
    int k;
    k = 0;
    while (res_q.size() < rd + n && k < 400) begin
      tick();
      k++;
    end
    check(tag, 64'(res_q.size() >= rd + n), 64'd1);
  endtask

  task automatic compare_next(input string tag, input logic [47:0] f);
    res_t r;
    if (res_q.size() > rd) begin
      r = res_q[rd];
      rd++;
      check({tag, ".data"}, 64'(r.d), 64'(f[47:16]));
      check({tag, ".crc"}, 64'(r.c), 64'(f[15:0]));
      check({tag, ".ok"}, 64'(r.ok), 64'(frame_ok(f)));
      check({tag, ".err"}, 64'(r.err), 64'(!frame_ok(f)));
    end else begin
      check({tag, ".present"}, 64'd0, 64'd1);
    end
  endtask

  initial begin
    logic [47:0] f, f2;
    logic [31:0] p;
    logic [15:0] c;
    logic [31:0] t0;
    logic [31:0] hd;
    logic [15:0] hc;
    int unsigned vs0, bs0;
    bit stable;
    logic [47:0] exp_q[$];

    rst = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    frame_start = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("rst.data", 64'(data_out), 64'd0);
    check("rst.crc", 64'(crc_rx), 64'd0);
    check("rst.ok", 64'(crc_ok), 64'd0);
    check("rst.err", 64'(crc_err), 64'd0);
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.ovr", 64'(overrun), 64'd0);
    rst = 1'b1;
    tick();

    // Random good frame leaves non-zero data behind, then reset lands mid-frame.
    out_ready = 1'b1;
    p = $urandom;
    f = {p, good_crc(p)};
    send_bits(f, 48, 1'b0);
    wait_results(1, "first.wait");
    compare_next("first", f);
    f = {$urandom, 16'h1234};
    send_bits(f, 20, 1'b0);
    check("mid.busy", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst.data", 64'(data_out), 64'd0);
    check("arst.crc", 64'(crc_rx), 64'd0);
    check("arst.busy", 64'(busy), 64'd0);
    check("arst.valid", 64'(out_valid), 64'd0);
    check("arst.ok", 64'(crc_ok), 64'd0);
    check("arst.ovr", 64'(overrun), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // All-zero frame: result present right after the edge that takes bit 48.
    out_ready = 1'b0;
    send_bits(48'h0, 48, 1'b0);
    check("zero.valid", 64'(out_valid), 64'd1);
    check("zero.busy", 64'(busy), 64'd0);
    check("zero.data", 64'(data_out), 64'd0);
    check("zero.crc", 64'(crc_rx), 64'd0);
    check("zero.ok", 64'(crc_ok), 64'd1);
    check("zero.err", 64'(crc_err), 64'd0);
    repeat (3) tick();
    check("zero.hold", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    check("zero.drop", 64'(out_valid), 64'd0);
    check("zero.okclr", 64'(crc_ok), 64'd0);
    rd = res_q.size();

    // Back-to-back good frames, gapless input, ready held high.
    send_bits(48'h00000001_8005, 48, 1'b0);
    send_bits(48'h00000002_800F, 48, 1'b0);
    wait_results(2, "b2b.wait");
    t0 = (res_q.size() > rd) ? res_q[rd].cyc : 32'd0;
    compare_next("b2b1", 48'h00000001_8005);
    check("b2b.spacing", 64'((res_q.size() > rd) ? res_q[rd].cyc - t0 : 32'd0), 64'd48);
    compare_next("b2b2", 48'h00000002_800F);
    check("b2b.ovr", 64'(overrun), 64'd0);
    tick();
    check("idle.keep", 64'(data_out), 64'h2);

    send_bits(48'h00000001_8004, 48, 1'b0);
    wait_results(1, "bad.wait");
    compare_next("bad", 48'h00000001_8004);

    // Randomized frames with gaps; every other one has a flipped CRC bit.
    for (int k = 0; k < 6; k++) begin
      p = $urandom;
      c = good_crc(p);
      if (k[0]) c = c ^ (16'h1 << $urandom_range(15, 0));
      exp_q.push_back({p, c});
      send_bits({p, c}, 48, 1'b1);
    end
    wait_results(6, "rand.wait");
    foreach (exp_q[k]) compare_next("rand", exp_q[k]);
    check("rand.ovr", 64'(overrun), 64'd0);

    // Gappy frame under backpressure, then a dropped bit in HOLD.
    out_ready = 1'b0;
    send_bits(48'h00000002_800F, 48, 1'b1);
    check("bp.valid", 64'(out_valid), 64'd1);
    hd = data_out;
    hc = crc_rx;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (!out_valid || data_out != 32'h2 || crc_rx != 16'h800F || !crc_ok) stable = 1'b0;
    end
    check("bp.stable", 64'(stable), 64'd1);
    check("bp.data", 64'(hd), 64'h2);
    check("bp.crc", 64'(hc), 64'h800F);
    bit_in = 1'b1;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    check("drop.ovr", 64'(overrun), 64'd1);
    check("drop.valid", 64'(out_valid), 64'd1);
    check("drop.data", 64'(data_out), 64'h2);
    check("drop.busy", 64'(busy), 64'd0);
    rd = res_q.size();
    out_ready = 1'b1;
    wait_results(1, "drop.wait");
    compare_next("drop", 48'h00000002_800F);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst2.ovr", 64'(overrun), 64'd0);

    // Stray bits in IDLE are ignored quietly.
    vs0 = vld_seen;
    bs0 = busy_seen;
    for (int k = 0; k < 100; k++) begin
      bit_in = 1'($urandom);
      bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    tick();
    check("stray.valid", 64'(vld_seen - vs0), 64'd0);
    check("stray.busy", 64'(busy_seen - bs0), 64'd0);
    check("stray.ovr", 64'(overrun), 64'd0);

    // Abort: a new start bit 30 bits into a frame.
    rd = res_q.size();
    f2 = {$urandom, 16'hBEEF};
    send_bits(f2, 30, 1'b0);
    send_bits(48'h00000001_8005, 48, 1'b0);
    wait_results(1, "abort.wait");
    repeat (5) tick();
    check("abort.count", 64'(res_q.size() - rd), 64'd1);
    compare_next("abort", 48'h00000001_8005);
    check("abort.ovr", 64'(overrun), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
